coeffs_loader: RTL and testbench
================================

// Module: coeffs_loader
// PURPOSE
//  Initiator side of the coefficient write interface. Receives a frame of FIR
//  coefficients as a byte stream (valid/ready, MSB byte first), assembles 16-bit
//  words, and issues one write per coefficient on write_address/coeffs_in/write_enable.
//  After the last write it pulses write_done, which write_done_capture turns into coeffs_en.
// PARAMETERS
//  NUM_COEFFS      64    coefficients per frame; addresses 0..NUM_COEFFS-1
//  ADDR_W          6     width of write_address; 2**ADDR_W >= NUM_COEFFS
//  DATA_W          16    coefficient width; fixed at 2 bytes
//  TIMEOUT_CYCLES  1024  idle cycles allowed between accepted bytes inside a frame
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous, active-low reset
//  clk_enable     in   1       sample-rate enable; coefficient sink captures only when high
//  start          in   1       1-cycle pulse: begin a new frame; ignored while busy
//  s_data         in   8       stream byte
//  s_valid        in   1       s_data valid
//  s_ready        out  1       loader accepts s_data this cycle
//  write_address  out  ADDR_W  coefficient address
//  coeffs_in      out  DATA_W  signed coefficient value
//  write_enable   out  1       write strobe to coefficient sink
//  write_done     out  1       1-cycle pulse: full frame written
//  busy           out  1       high from accepted start until return to IDLE
//  timeout_err    out  1       1-cycle pulse: frame aborted on timeout
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all outputs 0; address, word and timer cleared.
//  - Byte accept = s_valid & s_ready. s_ready=1 only in RECV_HI/RECV_LO.
//  - FSM:
//    IDLE:    start=1 -> RECV_HI, address<=0, busy<=1. Otherwise stay.
//    RECV_HI: accept -> word[15:8]<=s_data, -> RECV_LO.
//    RECV_LO: accept -> word[7:0]<=s_data, -> WRITE.
//    WRITE:   write_enable=1, write_address=address, coeffs_in=word, all held stable.
//             Leave on the first cycle with clk_enable=1 (sink captures that edge):
//             if address==NUM_COEFFS-1 -> DONE, else address+1 and -> RECV_HI.
//             No bytes accepted in WRITE.
//    DONE:    write_done=1 for exactly one cycle; -> IDLE; busy falls entering IDLE.
//  - write_enable, write_address and coeffs_in are registered; write_enable is 0
//    outside WRITE. address never wraps: the last address written is NUM_COEFFS-1.
//  - Timeout: timer counts cycles in RECV_HI/RECV_LO with no accept; cleared on
//    accept and on entering RECV_HI. Reaching TIMEOUT_CYCLES -> timeout_err one
//    cycle, -> IDLE, no write_done, no further writes. Partial writes stay in the
//    sink's working regs; the shadow is untouched since coeffs_en is not raised.
//    WRITE waiting on clk_enable does not time out.
//  - start while busy: ignored, no effect on frame or address.
//  - start and a valid byte in the same IDLE cycle: the byte is not accepted
//    (s_ready=0 in IDLE); the first byte is taken the following cycle.
//  - Reset mid-frame: immediate return to IDLE, write_enable dropped asynchronously,
//    no write_done.
//  - Minimum frame latency with clk_enable=1 and s_valid=1 throughout:
//    3 cycles per coefficient + 1 DONE cycle = 3*NUM_COEFFS+1 cycles after start.
// TESTING
//  1 clk_enable=1, start, stream 128 bytes encoding coeff k = 16'h0100+k
//    -> 64 writes, addr 0..63, data 0x0100..0x013F, write_done once, 193 cycles.
//  2 clk_enable high 1 cycle in 4 -> each write_enable held until a clk_enable
//    cycle, exactly one captured write per address, data matches.
//  3 Bytes 0xFF,0x85 for addr 0 -> coeffs_in=16'hFF85 (-123 signed).
//  4 Stop s_valid after 10 bytes for 1024 cycles -> timeout_err pulse, busy=0,
//    no write_done; a new start then loads from addr 0.
//  5 start pulsed at byte 50 -> ignored; frame completes normally with 64 writes.
//  6 rst=0 during WRITE of addr 20 -> write_enable=0 immediately, all outputs 0,
//    IDLE after release.

Source files
------------

// File: rtl/coeffs_loader.sv
// Coefficient frame loader: assembles MSB-first byte pairs from a valid/ready stream
// into 16-bit coefficients and writes them to addresses 0..NUM_COEFFS-1.
module coeffs_loader #(
    parameter int unsigned NUM_COEFFS     = 64,
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] coeffs_in,
    output logic              write_enable,
    output logic              write_done,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned       TimerW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_COEFFS - 1);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StRecvHi, StRecvLo, StWrite, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          hi_q, hi_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                we_q, we_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                to_q, to_d;
    logic                accept;

    assign s_ready = (state_q == StRecvHi) || (state_q == StRecvLo);
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        word_d  = word_q;
        timer_d = timer_q;
        to_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRecvHi;
                    addr_d  = '0;
                    timer_d = '0;
                end
            end
            StRecvHi, StRecvLo: begin
                if (accept) begin
                    timer_d = '0;
                    if (state_q == StRecvHi) begin
                        hi_d    = s_data;
                        state_d = StRecvLo;
                    end else begin
                        word_d  = DATA_W'({hi_q, s_data});
                        state_d = StWrite;
                    end
                end else if (timer_q == TimerMax) begin
                    // Abort the frame; the sink never sees write_done.
                    state_d = StIdle;
                    to_d    = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWrite: begin
                if (clk_enable) begin
                    if (addr_q == LastAddr) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        timer_d = '0;
                        state_d = StRecvHi;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        we_d   = (state_d == StWrite);
        done_d = (state_d == StDone);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            hi_q    <= '0;
            word_q  <= '0;
            timer_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            word_q  <= word_d;
            timer_q <= timer_d;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign write_address = addr_q;
    assign coeffs_in     = word_q;
    assign write_enable  = we_q;
    assign write_done    = done_q;
    assign busy          = busy_q;
    assign timeout_err   = to_q;

endmodule

// File: tb/tb_coeffs_loader.sv
// Directed bench for coeffs_loader: a per-cycle monitor checks every captured write
// against the expected coefficient list built from the byte stream being sent.
module tb_coeffs_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [5:0]  write_address;
    logic [15:0] coeffs_in;
    logic        write_enable;
    logic        write_done;
    logic        busy;
    logic        timeout_err;

    coeffs_loader #(
        .NUM_COEFFS    (64),
        .ADDR_W        (6),
        .DATA_W        (16),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_enable   (clk_enable),
        .start        (start),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .write_address(write_address),
        .coeffs_in    (coeffs_in),
        .write_enable (write_enable),
        .write_done   (write_done),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, cap_cnt = 0, cap_base = 0, done_cnt = 0, to_cnt = 0;
    int done_cyc = 0, start_cyc = 0, to_cyc = 0, last_acc_cyc = 0;
    int ce_mode = 1;
    bit abort = 1'b0;
    logic [15:0] exp_data [64];
    logic [15:0] cap_log  [64];
    logic [7:0]  tx       [128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Sink-side view: a write is captured on a cycle with write_enable and clk_enable.
    initial begin
        bit          prev_we = 1'b0, prev_cap = 1'b0;
        logic [5:0]  prev_addr = '0;
        logic [15:0] prev_data = '0;
        int          idx;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (start && !busy) start_cyc = cyc;
                if (write_done) begin done_cnt++; done_cyc = cyc; end
                if (timeout_err) begin to_cnt++; to_cyc = cyc; end
                if (write_enable) begin
                    chk("we_implies_busy", busy, 1);
                    if (prev_we && !prev_cap) begin
                        chk("hold_addr", write_address, prev_addr);
                        chk("hold_data", coeffs_in, prev_data);
                    end
                    if (clk_enable) begin
                        idx = cap_cnt - cap_base;
                        if (idx < 64) begin
                            chk("wr_addr", write_address, idx);
                            chk("wr_data", coeffs_in, exp_data[idx]);
                            cap_log[idx] = coeffs_in;
                        end else begin
                            chk("wr_count", idx, 63);
                        end
                        cap_cnt++;
                    end
                end
                prev_we   = write_enable;
                prev_cap  = clk_enable;
                prev_addr = write_address;
                prev_data = coeffs_in;
            end else begin
                prev_we = 1'b0;
            end
        end
    end

    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ce_mode)
                0: clk_enable = 1'b0;
                1: clk_enable = 1'b1;
                default: begin clk_enable = (k % 4 == 0); k++; end
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_pattern(input int kind);
        logic [15:0] w;
        for (int k = 0; k < 64; k++) begin
            case (kind)
                0: w = 16'h0100 + 16'(k);
                1: w = 16'(k * 37) ^ 16'h5A5A;
                default: w = (k == 0) ? 16'hFF85 : (16'h8000 | 16'(k * 3));
            endcase
            exp_data[k]  = w;
            tx[2*k]      = w[15:8];
            tx[2*k + 1]  = w[7:0];
        end
    endtask

    task automatic begin_frame();
        cap_base = cap_cnt;
        @(posedge clk);
        #1;
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = tx[0];
        @(negedge clk);
        chk("idle_no_accept", s_ready, 0);
    endtask

    task automatic send_bytes(input int n, input int start_at);
        int idx = 0;
        int guard = 0;
        bit pulsed = 1'b0;
        while (idx < n && !abort && guard < 4000) begin
            @(posedge clk);
            #1;
            s_valid = 1'b1;
            s_data  = tx[idx];
            if (idx == start_at && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
            if (s_valid && s_ready) begin
                idx++;
                last_acc_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        start   = 1'b0;
        if (!abort) chk("bytes_sent", idx, n);
    endtask

    task automatic wait_idle(input int budget);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (busy && g < budget);
        chk("idle_reached", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic full_frame(input int start_at, input int budget, input string tag);
        int d0;
        d0 = done_cnt;
        begin_frame();
        send_bytes(128, start_at);
        wait_idle(budget);
        chk({tag, "_writes"}, cap_cnt - cap_base, 64);
        chk({tag, "_done"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0, t0, g, gap;
        #3 rst = 1'b0;
        #20;
        chk("rst_we", write_enable, 0);
        chk("rst_addr", write_address, 0);
        chk("rst_data", coeffs_in, 0);
        chk("rst_done", write_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_to", timeout_err, 0);
        chk("rst_ready", s_ready, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back stream, sink enabled every cycle.
        load_pattern(0);
        full_frame(-1, 100, "t1");
        chk("t1_latency", done_cyc - start_cyc, 193);
        chk("t1_first", cap_log[0], 16'h0100);
        chk("t1_last", cap_log[63], 16'h013F);

        // Sink enabled one cycle in four.
        ce_mode = 2;
        load_pattern(1);
        full_frame(-1, 200, "t2");
        ce_mode = 1;

        // Negative coefficient at address 0.
        load_pattern(2);
        full_frame(-1, 100, "t3");
        chk("t3_word", cap_log[0], 16'hFF85);
        chk("t3_signed", 32'(int'($signed(cap_log[0]))), 32'hFFFF_FF85);

        // Stream stalls after 10 bytes.
        load_pattern(0);
        d0 = done_cnt;
        t0 = to_cnt;
        begin_frame();
        send_bytes(10, -1);
        g = 0;
        while (to_cnt == t0 && g < 1200) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk("t4_timeout_pulse", to_cnt - t0, 1);
        chk("t4_busy", busy, 0);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_partial", cap_cnt - cap_base, 5);
        gap = to_cyc - last_acc_cyc;
        chk("t4_gap_window", (gap >= 1025 && gap <= 1028), 1);
        load_pattern(1);
        full_frame(-1, 100, "t4_reload");

        // Stray start mid-frame must be ignored.
        load_pattern(0);
        full_frame(50, 100, "t5");
        chk("t5_latency", done_cyc - start_cyc, 193);

        // Reset asserted while address 20 is being written.
        load_pattern(1);
        d0 = done_cnt;
        abort = 1'b0;
        begin_frame();
        fork
            send_bytes(128, -1);
            begin
                int w = 0;
                while (!(write_enable && write_address == 6'd20) && w < 500) begin
                    @(negedge clk);
                    w++;
                end
                chk("t6_at_addr20", write_address, 20);
                #1 rst = 1'b0;
                #1;
                chk("t6_we", write_enable, 0);
                chk("t6_addr", write_address, 0);
                chk("t6_data", coeffs_in, 0);
                chk("t6_busy", busy, 0);
                chk("t6_ready", s_ready, 0);
                chk("t6_done", write_done, 0);
                abort = 1'b1;
            end
        join
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_ready", s_ready, 0);
        chk("t6_no_done", done_cnt - d0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
